// File: rtl/feature_extractor_pkg.sv
`default_nettype none
// ============================================================================
// feature_extractor_pkg : frame geometry, Laplacian kernel and FSM state type
// Rev 1.0
// ============================================================================
package feature_extractor_pkg;

   localparam int IMG_WIDTH  = 32;
   localparam int IMG_HEIGHT = 32;
   localparam int CONV_W     = IMG_WIDTH - 2;
   localparam int POOL_W     = CONV_W / 2;
   localparam int OUT_W      = 22;
   localparam int PIX_W      = 8;
   // 13 signed bits hold the full +/-2040 kernel range with margin
   localparam int SUM_W      = 13;

   localparam int ROW_W  = $clog2(IMG_HEIGHT);
   localparam int COL_W  = $clog2(IMG_WIDTH);
   localparam int PCOL_W = $clog2(POOL_W);
   localparam int RES_W  = $clog2(POOL_W * POOL_W + 1);

   localparam logic signed [4:0] KERNEL [3][3] = '{
      '{-5'sd1, -5'sd1, -5'sd1},
      '{-5'sd1,  5'sd8, -5'sd1},
      '{-5'sd1, -5'sd1, -5'sd1}
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fe_state_e;

endpackage
`default_nettype wire

// File: rtl/feature_extractor_conv3x3_window.sv
`default_nettype none
// ============================================================================
// conv3x3_window : line buffers, 3x3 shift window and kernel multiply-add
// Rev 1.0
// ============================================================================
module conv3x3_window
   import feature_extractor_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    accept_i,
   input  logic [PIX_W-1:0]        pixel_i,
   input  logic [ROW_W-1:0]        row_i,
   input  logic [COL_W-1:0]        col_i,
   output logic signed [OUT_W-1:0] conv_o,
   output logic                    conv_valid_o,
   output logic                    conv_row_odd_o,
   output logic                    conv_col_odd_o
);

   logic [PIX_W-1:0]        lb_top_q [IMG_WIDTH];
   logic [PIX_W-1:0]        lb_mid_q [IMG_WIDTH];
   logic [PIX_W-1:0]        win_q    [3][2];
   logic [PIX_W-1:0]        taps     [3][3];
   logic signed [SUM_W-1:0] sum_d;

   logic signed [OUT_W-1:0] conv_q;
   logic                    conv_valid_q;
   logic                    row_odd_q;
   logic                    col_odd_q;

   // Rightmost window column is formed from the incoming pixel so the sum is ready on accept
   always_comb begin
      for (int ky = 0; ky < 3; ky++) begin
         taps[ky][0] = win_q[ky][0];
         taps[ky][1] = win_q[ky][1];
      end
      taps[0][2] = lb_top_q[col_i];
      taps[1][2] = lb_mid_q[col_i];
      taps[2][2] = pixel_i;
   end

   always_comb begin
      sum_d = '0;
      for (int ky = 0; ky < 3; ky++) begin
         for (int kx = 0; kx < 3; kx++) begin
            sum_d = sum_d + SUM_W'(KERNEL[ky][kx])
                          * $signed({{(SUM_W-PIX_W){1'b0}}, taps[ky][kx]});
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept_i) begin
         lb_top_q[col_i] <= lb_mid_q[col_i];
         lb_mid_q[col_i] <= pixel_i;
         for (int ky = 0; ky < 3; ky++) begin
            win_q[ky][0] <= win_q[ky][1];
            win_q[ky][1] <= taps[ky][2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         conv_q       <= '0;
         conv_valid_q <= 1'b0;
         row_odd_q    <= 1'b0;
         col_odd_q    <= 1'b0;
      end else begin
         conv_valid_q <= accept_i && (row_i >= ROW_W'(2)) && (col_i >= COL_W'(2));
         if (accept_i) begin
            conv_q    <= OUT_W'(sum_d);
            // conv index is image index minus 2, so parity is unchanged
            row_odd_q <= row_i[0];
            col_odd_q <= col_i[0];
         end
      end
   end

   assign conv_o         = conv_q;
   assign conv_valid_o   = conv_valid_q;
   assign conv_row_odd_o = row_odd_q;
   assign conv_col_odd_o = col_odd_q;

endmodule
`default_nettype wire

// File: rtl/feature_extractor.sv
`default_nettype none
// ============================================================================
// feature_extractor : 3x3 Laplacian + 2x2 max-pool streaming front end
// Rev 1.0
// ============================================================================
module feature_extractor
   import feature_extractor_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_signal,
   input  logic                    pixel_valid_in,
   input  logic [PIX_W-1:0]        pixel_in,
   output logic signed [OUT_W-1:0] final_result_out,
   output logic                    final_result_valid,
   output logic                    final_done_signal
);

   fe_state_e               state_q, state_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic [COL_W-1:0]        col_q, col_d;
   logic [PCOL_W-1:0]       pcol_q, pcol_d;
   logic [RES_W-1:0]        res_cnt_q, res_cnt_d;
   logic signed [OUT_W-1:0] result_q, result_d;
   logic                    valid_q, valid_d;
   logic                    done_q, done_d;

   logic signed [OUT_W-1:0] hold_q;
   logic signed [OUT_W-1:0] pool_buf_q [POOL_W];

   logic                    accept;
   logic                    last_pixel;
   logic signed [OUT_W-1:0] conv;
   logic                    conv_valid;
   logic                    conv_row_odd;
   logic                    conv_col_odd;
   logic signed [OUT_W-1:0] hmax;
   logic signed [OUT_W-1:0] vmax;

   conv3x3_window u_window (
      .clk            (clk),
      .rst            (rst),
      .accept_i       (accept),
      .pixel_i        (pixel_in),
      .row_i          (row_q),
      .col_i          (col_q),
      .conv_o         (conv),
      .conv_valid_o   (conv_valid),
      .conv_row_odd_o (conv_row_odd),
      .conv_col_odd_o (conv_col_odd)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      done_d     = 1'b0;
      last_pixel = (row_q == ROW_W'(IMG_HEIGHT - 1)) && (col_q == COL_W'(IMG_WIDTH - 1));
      case (state_q)
         ST_IDLE: begin
            if (start_signal) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (start_signal) begin
               state_d = ST_RUN;
            end else if (pixel_valid_in) begin
               accept = 1'b1;
               if (last_pixel) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (start_signal) begin
               state_d = ST_RUN;
            end else if (valid_q && (res_cnt_q == RES_W'(POOL_W * POOL_W))) begin
               // final result is on the output now; done follows one cycle later
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      row_d     = row_q;
      col_d     = col_q;
      pcol_d    = pcol_q;
      res_cnt_d = res_cnt_q;
      result_d  = result_q;
      valid_d   = 1'b0;
      hmax      = (hold_q > conv) ? hold_q : conv;
      vmax      = (pool_buf_q[pcol_q] > hmax) ? pool_buf_q[pcol_q] : hmax;
      if (start_signal) begin
         row_d     = '0;
         col_d     = '0;
         pcol_d    = '0;
         res_cnt_d = '0;
      end else begin
         if (accept) begin
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
               col_d = '0;
               row_d = last_pixel ? '0 : row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         if (conv_valid && conv_col_odd) begin
            pcol_d = (pcol_q == PCOL_W'(POOL_W - 1)) ? '0 : pcol_q + 1'b1;
            if (conv_row_odd) begin
               result_d  = vmax;
               valid_d   = 1'b1;
               res_cnt_d = res_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         row_q     <= '0;
         col_q     <= '0;
         pcol_q    <= '0;
         res_cnt_q <= '0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         row_q     <= row_d;
         col_q     <= col_d;
         pcol_q    <= pcol_d;
         res_cnt_q <= res_cnt_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   // Even conv rows park the horizontal pair max; odd rows consume it
   always_ff @(posedge clk) begin
      if (conv_valid && !start_signal) begin
         if (!conv_col_odd) begin
            hold_q <= conv;
         end else if (!conv_row_odd) begin
            pool_buf_q[pcol_q] <= hmax;
         end
      end
   end

   assign final_result_out   = result_q;
   assign final_result_valid = valid_q;
   assign final_done_signal  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_feature_extractor.sv
`default_nettype none
// tb_feature_extractor : directed and random frames against an arithmetic model,
// expected results queued at stimulus time and consumed by an output monitor.
module tb_feature_extractor;

   logic              clk            = 1'b0;
   logic              rst            = 1'b0;
   logic              start_signal   = 1'b0;
   logic              pixel_valid_in = 1'b0;
   logic [7:0]        pixel_in       = '0;
   logic signed [21:0] final_result_out;
   logic              final_result_valid;
   logic              final_done_signal;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   exp_t exp_q [$];
   int   done_q [$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   img    [32][32];
   int   pooled [15][15];
   int   got    [225];
   int   got_n  = 0;

   feature_extractor dut (
      .clk                (clk),
      .rst                (rst),
      .start_signal       (start_signal),
      .pixel_valid_in     (pixel_valid_in),
      .pixel_in           (pixel_in),
      .final_result_out   (final_result_out),
      .final_result_valid (final_result_valid),
      .final_done_signal  (final_done_signal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int kind);
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 32; c++) begin
            case (kind)
               0:       img[r][c] = 0;
               1:       img[r][c] = 100;
               2:       img[r][c] = (r == 10 && c == 10) ? 255 : 0;
               3:       img[r][c] = (c >= 16) ? 200 : 0;
               default: img[r][c] = int'($urandom_range(255));
            endcase
         end
      end
   endtask

   // Laplacian = 9*centre minus the sum of the whole 3x3 neighbourhood
   function automatic void compute_model();
      int conv [30][30];
      int m;
      for (int r = 0; r < 30; r++) begin
         for (int c = 0; c < 30; c++) begin
            conv[r][c] = 9 * img[r+1][c+1];
            for (int dy = 0; dy < 3; dy++)
               for (int dx = 0; dx < 3; dx++)
                  conv[r][c] -= img[r+dy][c+dx];
         end
      end
      for (int i = 0; i < 15; i++) begin
         for (int j = 0; j < 15; j++) begin
            m = conv[2*i][2*j];
            for (int a = 0; a < 2; a++)
               for (int b = 0; b < 2; b++)
                  if (conv[2*i+a][2*j+b] > m) m = conv[2*i+a][2*j+b];
            pooled[i][j] = m;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (final_result_valid) begin
         check("result_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("result_value", int'(final_result_out), mon_e.val);
            check("result_cycle", cyc, mon_e.cyc);
            if (got_n < 225) got[got_n] = int'(final_result_out);
            got_n++;
         end
         check("done_with_valid", int'(final_done_signal), 0);
      end
      if (final_done_signal) begin
         check("done_expected", int'(done_q.size() != 0), 1);
         if (done_q.size() != 0) check("done_cycle", cyc, done_q.pop_front());
      end
   end

   task automatic abort_frame(input bit by_reset);
      if (by_reset) rst = 1'b0;
      else          start_signal = 1'b1;
      pixel_valid_in = 1'b1;
      pixel_in       = 8'hFF;
      step();
      exp_q.delete();
      done_q.delete();
      if (by_reset) begin
         check("midrst_result", int'(final_result_out), 0);
         check("midrst_valid", int'(final_result_valid), 0);
         check("midrst_done", int'(final_done_signal), 0);
      end
      rst          = 1'b1;
      start_signal = 1'b0;
      // without a new start these pixels must produce nothing
      if (by_reset) begin
         for (int k = 0; k < 120; k++) begin
            pixel_valid_in = 1'b1;
            pixel_in       = 8'($urandom);
            step();
         end
      end
      pixel_valid_in = 1'b0;
      repeat (6) step();
   endtask

   // gap_mode: 0 none, 1 toggle every cycle, 2 random gaps
   task automatic run_frame(input int kind, input int gap_mode, input int abort_at, input bit by_reset);
      int   r, c;
      exp_t e;
      fill(kind);
      compute_model();
      got_n = 0;
      step();
      start_signal   = 1'b1;
      pixel_valid_in = 1'b1;
      pixel_in       = 8'($urandom);
      for (int n = 0; n < 1024; n++) begin
         r = n / 32;
         c = n % 32;
         step();
         start_signal   = 1'b0;
         pixel_valid_in = 1'b0;
         if (n == abort_at) begin
            abort_frame(by_reset);
            return;
         end
         if (gap_mode == 1) step();
         else if (gap_mode == 2) while ($urandom_range(99) < 30) step();
         pixel_valid_in = 1'b1;
         pixel_in       = 8'(img[r][c]);
         if (r >= 3 && c >= 3 && r % 2 == 1 && c % 2 == 1) begin
            e.val = pooled[(r-3)/2][(c-3)/2];
            e.cyc = cyc + 2;
            exp_q.push_back(e);
         end
         if (n == 1023) done_q.push_back(cyc + 3);
      end
      step();
      pixel_valid_in = 1'b0;
      repeat (8) step();
      check("frame_results_left", exp_q.size(), 0);
      check("frame_done_left", done_q.size(), 0);
      check("frame_result_count", got_n, 225);
   endtask

   initial begin
      repeat (3) step();
      check("reset_result", int'(final_result_out), 0);
      check("reset_valid", int'(final_result_valid), 0);
      check("reset_done", int'(final_done_signal), 0);
      rst = 1'b1;
      step();

      run_frame(0, 0, -1, 1'b0);
      run_frame(1, 0, -1, 1'b0);
      run_frame(2, 0, -1, 1'b0);
      check("impulse_p44", got[4*15+4], 2040);
      check("impulse_p55", got[5*15+5], 0);
      run_frame(3, 0, -1, 1'b0);
      for (int i = 0; i < 15; i++) check("step_col7", got[i*15+7], 600);
      run_frame(2, 1, -1, 1'b0);
      check("gapped_impulse_p44", got[4*15+4], 2040);
      run_frame(4, 2, -1, 1'b0);
      run_frame(4, 0, -1, 1'b0);
      run_frame(4, 2, 500, 1'b1);
      run_frame(2, 2, -1, 1'b0);
      check("post_reset_impulse_p44", got[4*15+4], 2040);
      run_frame(4, 0, 700, 1'b0);
      run_frame(4, 2, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
